// File: rtl/token_embedder.sv
// Token embedder: walks a zero-terminated token-ID list and copies each token's
// embedding row from the embedding SRAM into a contiguous activation SRAM region.
module token_embedder #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned EMB_DIM        = 4,
   parameter int unsigned EMB_ADDR_WIDTH = 8,
   parameter int unsigned ACT_ADDR_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_cs,
   output logic [ADDR_WIDTH-1:0]     o_tok_addr,
   input  logic [DATA_WIDTH-1:0]     i_tok_rdata,
   output logic [EMB_ADDR_WIDTH-1:0] o_emb_addr,
   input  logic [DATA_WIDTH-1:0]     i_emb_rdata,
   output logic [ACT_ADDR_WIDTH-1:0] o_act_addr,
   output logic [DATA_WIDTH-1:0]     o_act_wdata,
   output logic                      o_act_we,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [ADDR_WIDTH:0]       o_tok_count
);

   localparam int unsigned KW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
   localparam logic [KW-1:0] KLast = KW'(EMB_DIM - 1);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StTfetch = 3'd1;
   localparam logic [2:0] StTchk   = 3'd2;
   localparam logic [2:0] StStream = 3'd3;
   localparam logic [2:0] StDrain  = 3'd4;
   localparam logic [2:0] StDone   = 3'd5;

   logic [2:0]                r_state;
   logic [ADDR_WIDTH-1:0]     r_tok_addr;
   logic [ADDR_WIDTH:0]       r_tok_count;
   logic [EMB_ADDR_WIDTH-1:0] r_base;
   logic [EMB_ADDR_WIDTH-1:0] r_emb_last;
   logic [KW-1:0]             r_k;
   logic [ACT_ADDR_WIDTH-1:0] r_act_addr;
   logic                      r_we;

   logic [EMB_ADDR_WIDTH-1:0] w_base;
   logic [EMB_ADDR_WIDTH-1:0] w_emb_addr;

   // Only the low EMB_ADDR_WIDTH bits of the product matter, so truncate before multiplying.
   assign w_base     = EMB_ADDR_WIDTH'(i_tok_rdata) * EMB_ADDR_WIDTH'(EMB_DIM);
   assign w_emb_addr = r_base + EMB_ADDR_WIDTH'(r_k);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_tok_addr  <= '0;
         r_tok_count <= '0;
         r_base      <= '0;
         r_emb_last  <= '0;
         r_k         <= '0;
         r_act_addr  <= '0;
         r_we        <= 1'b0;
      end else begin
         // Write strobe trails each embedding read by the SRAM's one-cycle latency.
         r_we <= (r_state == StStream);
         if (r_we) begin
            r_act_addr <= r_act_addr + ACT_ADDR_WIDTH'(1);
         end
         case (r_state)
            StIdle, StDone: begin
               if (i_cs) begin
                  r_state     <= StTfetch;
                  r_tok_addr  <= '0;
                  r_act_addr  <= '0;
                  r_tok_count <= '0;
               end
            end
            StTfetch: r_state <= StTchk;
            StTchk: begin
               if (i_tok_rdata == '0) begin
                  r_state <= StDone;
               end else begin
                  r_base  <= w_base;
                  r_k     <= '0;
                  r_state <= StStream;
               end
            end
            StStream: begin
               r_emb_last <= w_emb_addr;
               r_k        <= r_k + KW'(1);
               if (r_k == KLast) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               r_tok_count <= r_tok_count + (ADDR_WIDTH+1)'(1);
               if (r_tok_addr == {ADDR_WIDTH{1'b1}}) begin
                  r_state <= StDone;
               end else begin
                  r_tok_addr <= r_tok_addr + ADDR_WIDTH'(1);
                  r_state    <= StTfetch;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_tok_addr  = r_tok_addr;
   assign o_emb_addr  = (r_state == StStream) ? w_emb_addr : r_emb_last;
   assign o_act_addr  = r_act_addr;
   assign o_act_wdata = r_we ? i_emb_rdata : '0;
   assign o_act_we    = r_we;
   assign o_busy      = (r_state != StIdle) && (r_state != StDone);
   assign o_done      = (r_state == StDone);
   assign o_tok_count = r_tok_count;

endmodule

// File: tb/tb_token_embedder.sv
// Bench for token_embedder: a cycle-cost model of each run is compared with the DUT every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_token_embedder;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int ED = 4;
   localparam int EAW = 8;
   localparam int ACW = 8;
   localparam int ACW2 = 5;
   localparam int P = ED + 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cs = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]   tok_addr, tok_addr2;
   logic [DW-1:0]   tok_rdata, emb_rdata;
   logic [EAW-1:0]  emb_addr, emb_addr2;
   logic [ACW-1:0]  act_addr;
   logic [ACW2-1:0] act_addr2;
   logic [DW-1:0]   act_wdata, act_wdata2;
   logic            act_we, act_we2, busy, busy2, done, done2;
   logic [AW:0]     tok_count, tok_count2;

   token_embedder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EMB_DIM(ED), .EMB_ADDR_WIDTH(EAW),
                    .ACT_ADDR_WIDTH(ACW)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_cs(cs), .o_tok_addr(tok_addr), .i_tok_rdata(tok_rdata),
      .o_emb_addr(emb_addr), .i_emb_rdata(emb_rdata), .o_act_addr(act_addr),
      .o_act_wdata(act_wdata), .o_act_we(act_we), .o_busy(busy), .o_done(done),
      .o_tok_count(tok_count));

   // Narrow activation address space so a 64-write run wraps the write pointer.
   token_embedder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EMB_DIM(ED), .EMB_ADDR_WIDTH(EAW),
                    .ACT_ADDR_WIDTH(ACW2)) u_dut_narrow (
      .i_clk(clk), .i_rst(rst), .i_cs(cs), .o_tok_addr(tok_addr2), .i_tok_rdata(tok_rdata),
      .o_emb_addr(emb_addr2), .i_emb_rdata(emb_rdata), .o_act_addr(act_addr2),
      .o_act_wdata(act_wdata2), .o_act_we(act_we2), .o_busy(busy2), .o_done(done2),
      .o_tok_count(tok_count2));

   logic [DW-1:0] tok_mem [16];
   logic [DW-1:0] emb_mem [256];
   logic [DW-1:0] act_mem [256];
   int cyc = 0;
   int we_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      tok_rdata <= tok_mem[tok_addr];
      emb_rdata <= emb_mem[emb_addr];
      if (act_we) begin
         act_mem[act_addr] <= act_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, cyc - start);
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Run model state, set by the stimulus process at the cs edge.
   bit chk_en = 1'b0;
   int start = 0;
   int n_run = 0;

   function automatic int run_len(input int n);
      return (n == 16) ? P * n : P * n + 2;
   endfunction

   int m_t, m_i, m_j, m_T;
   logic m_ew, m_ev;
   logic [63:0] m_ea, m_ed, m_ee;

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         m_t = cyc - start;
         m_T = run_len(n_run);
         m_ew = 1'b0; m_ev = 1'b0; m_ea = '0; m_ed = '0; m_ee = '0;
         if (m_t < P * n_run) begin
            m_i = m_t / P;
            m_j = m_t % P;
            if (m_j >= 3) begin
               m_ew = 1'b1;
               m_ea = 64'(ED * m_i + m_j - 3);
               m_ed = 64'(emb_mem[(int'(tok_mem[m_i]) * ED + m_j - 3) % 256]);
            end
            if (m_j >= 2 && m_j <= ED + 1) begin
               m_ev = 1'b1;
               m_ee = 64'((int'(tok_mem[m_i]) * ED + m_j - 2) % 256);
            end
         end
         chk("act_we", 64'(act_we), 64'(m_ew));
         chk("act_we_narrow", 64'(act_we2), 64'(m_ew));
         if (m_ew) begin
            chk("act_addr", 64'(act_addr), m_ea % 256);
            chk("act_addr_narrow", 64'(act_addr2), m_ea % 32);
            chk("act_wdata", 64'(act_wdata), m_ed);
            chk("act_wdata_narrow", 64'(act_wdata2), m_ed);
         end
         if (m_ev) begin
            chk("emb_addr", 64'(emb_addr), m_ee);
            chk("emb_addr_narrow", 64'(emb_addr2), m_ee);
         end
         chk("busy", 64'(busy), 64'(m_t < m_T));
         chk("busy_narrow", 64'(busy2), 64'(m_t < m_T));
         chk("done", 64'(done), 64'(m_t >= m_T));
         chk("done_narrow", 64'(done2), 64'(m_t >= m_T));
         chk("tok_count", 64'(tok_count), 64'(imin(m_t / P, n_run)));
         chk("tok_count_narrow", 64'(tok_count2), 64'(imin(m_t / P, n_run)));
         chk("tok_addr", 64'(tok_addr), 64'(imin(m_t / P, (n_run < 16) ? n_run : 15)));
         chk("tok_addr_narrow", 64'(tok_addr2), 64'(imin(m_t / P, (n_run < 16) ? n_run : 15)));
      end
   end

   function automatic int count_tokens();
      for (int i = 0; i < 16; i++) if (tok_mem[i] == '0) return i;
      return 16;
   endfunction

   int base_we;

   task automatic start_run();
      @(negedge clk);
      n_run = count_tokens();
      cs = 1'b1;
      start = cyc + 1;
      base_we = we_cnt;
      chk_en = 1'b1;
   endtask

   // cs is held until t reaches drop_t; every cycle of that is while busy.
   task automatic wait_done(input int drop_t, output int td);
      td = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (cyc - start >= drop_t) cs = 1'b0;
         if (done === 1'b1) begin
            td = cyc - start;
            break;
         end
      end
      if (td < 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic set_tokens(input int n, input bit rnd);
      for (int i = 0; i < 16; i++) begin
         if (i >= n) tok_mem[i] = '0;
         else if (rnd) tok_mem[i] = DW'($urandom_range(1, 255));
         else tok_mem[i] = DW'(i + 1);
      end
   endtask

   int exp1 [8];
   int td, tmax;

   initial begin
      exp1 = '{12, 13, 14, 15, 4, 5, 6, 7};
      for (int a = 0; a < 256; a++) emb_mem[a] = DW'(a);
      set_tokens(0, 1'b0);

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_act_we", 64'(act_we), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_tok_count", 64'(tok_count), 0);
      chk("rst_tok_addr", 64'(tok_addr), 0);
      chk("rst_act_addr", 64'(act_addr), 0);
      chk("rst_emb_addr", 64'(emb_addr), 0);
      chk("rst_act_wdata", 64'(act_wdata), 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      // Tokens {3,1,0}
      tok_mem[0] = 8'd3; tok_mem[1] = 8'd1;
      start_run();
      wait_done(0, td);
      chk("t1_done_cycle", 64'(td), 16);
      chk("t1_tok_count", 64'(tok_count), 2);
      chk("t1_we_pulses", 64'(we_cnt - base_we), 8);
      for (int k = 0; k < 8; k++) chk("t1_act_image", 64'(act_mem[k]), 64'(exp1[k]));
      repeat (3) @(negedge clk);

      // Empty sequence
      set_tokens(0, 1'b0);
      start_run();
      wait_done(0, td);
      chk("empty_done_cycle", 64'(td), 2);
      chk("empty_tok_count", 64'(tok_count), 0);
      chk("empty_we_pulses", 64'(we_cnt - base_we), 0);
      repeat (2) @(negedge clk);

      // Full 16-token sequence, no terminator
      set_tokens(16, 1'b0);
      start_run();
      wait_done(0, td);
      chk("full_done_cycle", 64'(td), 112);
      chk("full_tok_count", 64'(tok_count), 16);
      chk("full_tok_addr", 64'(tok_addr), 15);
      chk("full_we_pulses", 64'(we_cnt - base_we), 64);
      chk("full_act_first", 64'(act_mem[0]), 4);
      chk("full_act_last", 64'(act_mem[63]), 67);
      repeat (2) @(negedge clk);

      // Token 255: base truncates to 252
      set_tokens(0, 1'b0);
      tok_mem[0] = 8'd255;
      start_run();
      wait_done(0, td);
      chk("t255_done_cycle", 64'(td), 9);
      for (int k = 0; k < 4; k++) chk("t255_act_image", 64'(act_mem[k]), 64'(252 + k));
      repeat (2) @(negedge clk);

      // Reset during STREAM of the second token, then a clean re-run
      for (int a = 0; a < 256; a++) emb_mem[a] = DW'(a) ^ 8'hA5;
      tok_mem[0] = 8'd3; tok_mem[1] = 8'd1;
      start_run();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         cs = 1'b0;
         if (cyc - start == 10) break;
      end
      chk_en = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_act_we", 64'(act_we), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_tok_count", 64'(tok_count), 0);
      chk("mid_rst_tok_addr", 64'(tok_addr), 0);
      chk("mid_rst_act_addr", 64'(act_addr), 0);
      chk("mid_rst_act_wdata", 64'(act_wdata), 0);
      chk("mid_rst_emb_addr", 64'(emb_addr), 0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      chk("post_rst_act_we", 64'(act_we), 0);
      chk("post_rst_done", 64'(done), 0);
      start_run();
      wait_done(0, td);
      chk("rerun_done_cycle", 64'(td), 16);
      for (int k = 0; k < 8; k++) chk("rerun_act_image", 64'(act_mem[k]), 64'(exp1[k] ^ 'hA5));
      repeat (2) @(negedge clk);

      // cs held through a run, then re-pulsed in DONE
      for (int a = 0; a < 256; a++) emb_mem[a] = DW'($urandom);
      set_tokens(3, 1'b1);
      tmax = run_len(3);
      start_run();
      wait_done(tmax - 1, td);
      chk("held_done_cycle", 64'(td), 64'(tmax));
      repeat (3) @(negedge clk);
      start_run();
      wait_done(0, td);
      chk("repulse_done_cycle", 64'(td), 64'(tmax));
      chk("repulse_tok_count", 64'(tok_count), 3);
      repeat (2) @(negedge clk);

      // Randomized runs with random cs hold lengths
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < 256; a++) emb_mem[a] = DW'($urandom);
         set_tokens(int'($urandom_range(0, 16)), 1'b1);
         tmax = run_len(count_tokens());
         start_run();
         wait_done(int'($urandom_range(0, tmax - 1)), td);
         chk("rand_done_cycle", 64'(td), 64'(tmax));
         repeat (int'($urandom_range(1, 4))) @(negedge clk);
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
